ram_arbiter: RTL
================

# ram_arbiter

Two-requester arbiter that shares one single-port synchronous RAM (one-cycle registered read, write-on-clock) between the core's instruction-fetch port (M0, read-only) and data port (M1, read/write). It grants at most one access per cycle, routes the winner's address and data to the RAM and returns read data to the correct requester one cycle later. Each requester sees its own read data held stable between reads. It sits between the core's fetch/LSU and the on-chip RAM.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 12, RAM word address width
- i_clk  input  1  clock; all state updates on rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_m0_req  input  1  M0 read request
- i_m0_addr  input  ADDR_WIDTH  M0 word address
- o_m0_gnt  output  1  M0 request accepted this cycle
- o_m0_rvalid  output  1  M0 read data valid
- o_m0_rdata  output  DATA_WIDTH  M0 read data
- i_m1_req  input  1  M1 request
- i_m1_we  input  1  M1 write (1) / read (0)
- i_m1_addr  input  ADDR_WIDTH  M1 word address
- i_m1_wdata  input  DATA_WIDTH  M1 write data
- o_m1_gnt  output  1  M1 request accepted this cycle
- o_m1_rvalid  output  1  M1 read data valid
- o_m1_rdata  output  DATA_WIDTH  M1 read data
- o_ram_we  output  1  RAM write enable
- o_ram_addr  output  ADDR_WIDTH  RAM address
- o_ram_wrdata  output  DATA_WIDTH  RAM write data
- i_ram_rdata  input  DATA_WIDTH  RAM read data (valid the cycle after the address)

## Operation
- Handshake: a request is held (req, addr, we, wdata stable) until gnt is seen high in the same cycle. gnt is combinational from req and arbitration state. A request that is not granted is not queued; the requester keeps req high.
- Arbitration: if only one req is high, that requester wins. On a conflict the policy is set by Configuration. Exactly one gnt at most per cycle. Both gnt are 0 while i_rst=1.
- RAM drive: on a grant, o_ram_addr equals the winner's addr. o_ram_we equals i_m1_we & o_m1_gnt, and o_m0 never writes. o_ram_wrdata always equals i_m1_wdata. With no grant: o_ram_we=0 and o_ram_addr=i_m0_addr.
- Response tag: registered 2-bit {rd0, rd1} is set on a granted read (M0 grant, or M1 grant with we=0) and cleared otherwise.
- Read return: o_mX_rvalid equals the tag bit. While rvalid=1, o_mX_rdata equals i_ram_rdata (pass-through). On that same edge, i_ram_rdata is captured into a per-port hold register. While rvalid=0, o_mX_rdata equals the hold register.
- Writes produce no rvalid. The gnt cycle is the write's completion.
- Back-to-back: a new grant is allowed every cycle, including the cycle in which a previous read returns. Throughput is 1 access/cycle.
- Same-address read following a write (write at cycle N, read granted at N+1) returns the new data. This relies on the RAM's write-before-next-read timing; no bypass is needed.

## Timing
- Grant latency is 0 cycles (same cycle as req). Read latency is 1 cycle: rvalid and rdata appear in the cycle after gnt.
- Reset values: o_m0_rvalid=0, o_m1_rvalid=0, o_m0_rdata=0, o_m1_rdata=0 (hold registers cleared), response tag=00, round-robin pointer=M1 (so M0 wins the first conflict).
- Reset mid-operation: asserting i_rst in the cycle after a read grant suppresses that rvalid; the returning data is discarded and the hold registers read 0. Requests presented during reset are ignored (no gnt, o_ram_we=0).
- The first grant is possible in the first cycle with i_rst=0.

## Configuration
- RAM_ARB_RR_EN defined: round-robin arbitration on conflicts.
  - A 1-bit last-winner pointer updates on every grant. On a conflict, the requester that did not win last is granted.
  - A requester never waits more than 1 conflicting cycle.
- RAM_ARB_RR_EN undefined: fixed priority, M1 (data) always wins conflicts.
  - M0 waits while i_m1_req=1.
  - The pointer logic is absent.

## Test plan
- Reset, then M0 read addr 0x010 holding 0xDEADBEEF: gnt0=1 at cycle 0 → rvalid0=1, rdata0=0xDEADBEEF at cycle 1. o_m0_rdata stays 0xDEADBEEF afterwards with rvalid0=0.
- M1 write 0x12345678 to 0x020 at cycle 0, M1 read 0x020 at cycle 1 → o_ram_we=1 only at cycle 0; rvalid1=1, rdata1=0x12345678 at cycle 2; rvalid0 never asserts.
- Both req high continuously for 4 cycles with RAM_ARB_RR_EN → grants M0, M1, M0, M1. Without the macro → M1 all 4 cycles and gnt0=0.
- Back-to-back reads alternating M0 at 0x001 and M1 at 0x002 on a single requester active per cycle → one rvalid per cycle, each routed to the correct port with the correct word, and no cross-talk in the other port's hold value.
- M0 read granted at cycle 0, i_rst=1 at cycle 1 → rvalid0=0 and rdata0=0 at cycle 1. gnt0=0 during reset even with i_m0_req=1.
- M1 write with i_m1_req=1 while M0 also requests (fixed priority) → o_ram_we=1, o_ram_addr=M1 address, and M0 is granted in the cycle after M1 drops req.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for one single-port synchronous RAM: M0 fetch (read-only), M1 data (read/write).
// Define RAM_ARB_RR_EN for round-robin conflict resolution; otherwise M1 has fixed priority.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_m0_req,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  output logic                  o_m0_gnt,
  output logic                  o_m0_rvalid,
  output logic [DATA_WIDTH-1:0] o_m0_rdata,
  input  logic                  i_m1_req,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_wdata,
  output logic                  o_m1_gnt,
  output logic                  o_m1_rvalid,
  output logic [DATA_WIDTH-1:0] o_m1_rdata,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wrdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);

  logic                  gnt0;
  logic                  gnt1;
  logic                  rd0;
  logic                  rd1;
  logic [DATA_WIDTH-1:0] hold0;
  logic [DATA_WIDTH-1:0] hold1;

`ifdef RAM_ARB_RR_EN
  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  logic last_win;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (i_m0_req && i_m1_req) begin
        gnt0 = (last_win == LAST_M1);
        gnt1 = (last_win == LAST_M0);
      end else begin
        gnt0 = i_m0_req;
        gnt1 = i_m1_req;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_win <= LAST_M1;
    end else if (gnt0) begin
      last_win <= LAST_M0;
    end else if (gnt1) begin
      last_win <= LAST_M1;
    end
  end
`else
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      gnt1 = i_m1_req;
      gnt0 = i_m0_req && !i_m1_req;
    end
  end
`endif

  assign o_m0_gnt     = gnt0;
  assign o_m1_gnt     = gnt1;
  assign o_ram_we     = gnt1 && i_m1_we;
  assign o_ram_addr   = gnt1 ? i_m1_addr : i_m0_addr;
  assign o_ram_wrdata = i_m1_wdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd0   <= 1'b0;
      rd1   <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      rd0 <= gnt0;
      rd1 <= gnt1 && !i_m1_we;
      if (rd0) begin
        hold0 <= i_ram_rdata;
      end
      if (rd1) begin
        hold1 <= i_ram_rdata;
      end
    end
  end

  // Reset masks a read returning in the reset cycle, so the port never sees stale data.
  assign o_m0_rvalid = rd0 && !i_rst;
  assign o_m1_rvalid = rd1 && !i_rst;
  assign o_m0_rdata  = i_rst ? '0 : (rd0 ? i_ram_rdata : hold0);
  assign o_m1_rdata  = i_rst ? '0 : (rd1 ? i_ram_rdata : hold1);

endmodule
